// File: rtl/mod_mul_rdx.sv
// Radix-2^RBITS interleaved modular multiplier, y = a*b mod m.
// Define MODMUL_EARLY_TERM_EN to end RUN once the remaining a bits are zero.
module mod_mul_rdx #(
    parameter int NBITS = 128,
    parameter int RBITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] y,
    output logic             busy
);

    localparam int STEPS = NBITS / RBITS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NBITS-1:0] t_c, acc_c, b_nxt;
    logic             last;

    // s < 2m; the sign of s-m at NBITS+2 bits picks s or s-m
    function automatic logic [NBITS-1:0] red(
        input logic [NBITS:0]   s,
        input logic [NBITS-1:0] md
    );
        logic [NBITS+1:0] d;
        d = {1'b0, s} - {2'b00, md};
        return d[NBITS+1] ? s[NBITS-1:0] : d[NBITS-1:0];
    endfunction

    function automatic logic [NBITS-1:0] dbl(
        input logic [NBITS-1:0] x,
        input logic [NBITS-1:0] md
    );
        return red({x, 1'b0}, md);
    endfunction

    always_comb begin
        t_c   = b_q;
        acc_c = acc_q;
        for (int j = 0; j < RBITS; j++) begin
            if (j != 0) t_c = dbl(t_c, m_q);
            if (a_q[j]) acc_c = red({1'b0, acc_c} + {1'b0, t_c}, m_q);
        end
        b_nxt = dbl(t_c, m_q);
    end

`ifdef MODMUL_EARLY_TERM_EN
    assign last = ((a_q >> RBITS) == '0) || (cnt_q == CW'(STEPS - 1));
`else
    assign last = (cnt_q == CW'(STEPS - 1));
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_c;
                b_d   = b_nxt;
                a_d   = a_q >> RBITS;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    y_d     = acc_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign y         = y_q;

endmodule

// File: tb/tb_mod_mul_rdx.sv
// Self-checking bench for mod_mul_rdx: directed cases, reset abort,
// backpressure and random transactions against a wide-arithmetic model.
module tb_mod_mul_rdx;

    localparam int N = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [N-1:0] a, b, m, y;
    logic         iv1, ir1, ov1, bz1;
    logic         iv4, ir4, ov4, bz4;
    logic [N-1:0] y1, y4;

    int n_chk  = 0;
    int n_fail = 0;

    mod_mul_rdx #(.NBITS(N), .RBITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    mod_mul_rdx #(.NBITS(N), .RBITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .m(m), .out_valid(ov1), .out_ready(1'b1),
        .y(y1), .busy(bz1)
    );

    mod_mul_rdx #(.NBITS(N), .RBITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a), .b(b), .m(m), .out_valid(ov4), .out_ready(1'b1),
        .y(y4), .busy(bz4)
    );

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] model(input logic [N-1:0] x,
                                           input logic [N-1:0] z,
                                           input logic [N-1:0] md);
        logic [2*N-1:0] p;
        logic [2*N-1:0] r;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, z};
        r = p % {{N{1'b0}}, md};
        return r[N-1:0];
    endfunction

    function automatic int exp_lat(input logic [N-1:0] x, input int rb);
`ifdef MODMUL_EARLY_TERM_EN
        int msb;
        int k;
        msb = -1;
        for (int i = 0; i < N; i++) if (x[i]) msb = i;
        k = (msb + rb) / rb;
        return (k < 1) ? 1 : k;
`else
        return (x === x) ? N / rb : N / rb;
`endif
    endfunction

    task automatic txn(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic [N-1:0] tm, input int hold,
                       input string tag);
        logic [N-1:0] ey;
        int           lat;
        ey = model(ta, tb, tm);
        @(negedge clk);
        chk({tag, " in_ready idle"}, N'(in_ready), N'(1));
        a        = ta;
        b        = tb;
        m        = tm;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rnd128();
        b = rnd128();
        m = rnd128();
        chk({tag, " busy"}, N'(busy), N'(1));
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, N'(lat), N'(exp_lat(ta, 2)));
        chk({tag, " y"}, y, ey);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, N'(out_valid), N'(1));
            chk({tag, " hold y"}, y, ey);
            chk({tag, " hold in_ready"}, N'(in_ready), N'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " post valid"}, N'(out_valid), N'(0));
        chk({tag, " post in_ready"}, N'(in_ready), N'(1));
        chk({tag, " post y"}, y, ey);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] bigm, ra, rb, rm;
        int           l1, l4, w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        iv1       = 1'b0;
        iv4       = 1'b0;
        a         = '0;
        b         = '0;
        m         = '0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", N'(in_ready), N'(1));
        chk("rst out_valid", N'(out_valid), N'(0));
        chk("rst busy", N'(busy), N'(0));
        chk("rst y", y, '0);
        rst_n = 1'b1;

        txn(N'(45), N'(77), N'(97), 0, "t45");
        txn(N'(0), N'(50), N'(97), 0, "a0");
        txn(N'(1), N'(96), N'(97), 5, "hold");

        bigm = '1 - N'(158);
        txn(bigm - 1, bigm - 1, bigm, 1, "big2");

        @(negedge clk);
        a   = bigm - 1;
        b   = bigm - 1;
        m   = bigm;
        iv1 = 1'b1;
        iv4 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv4 = 1'b0;
        l1  = 0;
        l4  = 0;
        for (int c = 1; c <= 300 && (l1 == 0 || l4 == 0); c++) begin
            @(posedge clk);
            #1;
            if (ov1 && l1 == 0) l1 = c;
            if (ov4 && l4 == 0) l4 = c;
        end
        chk("big1 latency", N'(l1), N'(exp_lat(bigm - 1, 1)));
        chk("big4 latency", N'(l4), N'(exp_lat(bigm - 1, 4)));
        chk("big1 y", y1, N'(1));
        chk("big4 y", y4, N'(1));

        @(negedge clk);
        a        = N'(45);
        b        = N'(77);
        m        = N'(97);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", N'(in_ready), N'(1));
        chk("abort out_valid", N'(out_valid), N'(0));
        chk("abort busy", N'(busy), N'(0));
        chk("abort y", y, '0);
        repeat (2) @(negedge clk);
        chk("abort held valid", N'(out_valid), N'(0));
        rst_n = 1'b1;
        txn(N'(45), N'(77), N'(97), 0, "after rst");

        for (int i = 0; i < 250; i++) begin
            w  = $urandom_range(2, N);
            rm = rnd128() >> (N - w);
            if (rm < 2) rm = N'(2);
            ra = rnd128() % rm;
            rb = rnd128() % rm;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(64, 127);
            txn(ra, rb, rm, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
